// File: rtl/sr_mul_unit.sv
// sr_mul_unit: iterative 32x32 shift-add multiplier returning the low 32 bits of a_bi*b_bi.
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - asynchronous active-high reset
//   start_i - operation request (level), sampled only in IDLE
//   a_bi    - multiplicand, latched on the start edge
//   b_bi    - multiplier, latched on the start edge
//   busy_o  - high while an operation is in RUN or DONE
//   done_o  - one-cycle completion pulse (state DONE)
//   y_bo    - result, held from one completion to the next
// Define SR_MUL_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module sr_mul_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_bi,
    input  logic [31:0] b_bi,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] y_bo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]  state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplr;
    logic [4:0]  count;
    logic [31:0] accNext;
    logic        lastStep;
    assign accNext = acc + (mplr[0] ? mcand : 32'd0);
`ifdef SR_MUL_EARLY_EXIT_EN
    // after this step the multiplier is mplr>>1; once it is zero no further adds can occur
    assign lastStep = (count == 5'd31) || (mplr[31:1] == 31'd0);
`else
    assign lastStep = (count == 5'd31);
`endif
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            count <= '0;
            y_bo  <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    mcand <= a_bi;
                    mplr  <= b_bi;
                    acc   <= '0;
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= accNext;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + 5'd1;
                    if (lastStep) begin
                        y_bo  <= accNext;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_mul_unit.sv
// tb_sr_mul_unit: self-checking bench for sr_mul_unit (table vectors, corner sequences, random ops).
module tb_sr_mul_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] aIn = '0;
    logic [31:0] bIn = '0;
    logic        busy;
    logic        done;
    logic [31:0] y;
    int          nChecks = 0;
    int          nFail = 0;
`ifdef SR_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;
    vec_t vecs[8];
    sr_mul_unit dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .a_bi   (aIn),
        .b_bi   (bIn),
        .busy_o (busy),
        .done_o (done),
        .y_bo   (y)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    // cycles spent in RUN: 32 in full mode, else position of the highest set multiplier bit (min 1)
    function automatic int latOf(input logic [31:0] b);
        int l = 1;
        for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
        return EARLY ? l : 32;
    endfunction
    // called #1 after an edge with the unit idle; returns #1 after the edge leaving DONE
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] expY;
        int          n;
        logic        busyOk;
        expY = a * b;
        start = 1'b1;
        aIn = a;
        bIn = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        aIn = $urandom;
        bIn = $urandom;
        chk({tag, " busy after start"}, 32'(busy), 32'd1);
        n = 0;
        busyOk = 1'b1;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) busyOk = 1'b0;
        end
        chk({tag, " latency"}, 32'(n), 32'(latOf(b)));
        chk({tag, " result"}, y, expY);
        chk({tag, " busy held"}, 32'(busyOk), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
        chk({tag, " busy released"}, 32'(busy), 32'd0);
        chk({tag, " result held"}, y, expY);
    endtask
    initial begin
        int   n;
        logic sawDone;
        vecs[0] = '{32'd3, 32'd5, 32'd15};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[3] = '{32'd0, 32'd1234, 32'd0};
        vecs[4] = '{32'd1, 32'h8000_0000, 32'h8000_0000};
        vecs[5] = '{32'd12345, 32'd0, 32'd0};
        vecs[6] = '{32'd7, 32'd6, 32'd42};
        vecs[7] = '{32'h1234_5678, 32'd16, 32'h2345_6780};
        #2 rst = 1'b1;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset y", y, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle without start", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec%0d model", i), vecs[i].a * vecs[i].b, vecs[i].y);
            runOp(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
        end
        // back-to-back with start held high and operands changed mid-run
        start = 1'b1;
        aIn = 32'd7;
        bIn = 32'd6;
        @(posedge clk);
        #1;
        aIn = 32'd2;
        bIn = 32'd9;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b first latency", 32'(n), 32'(latOf(32'd6)));
        chk("b2b first result", y, 32'd42);
        @(posedge clk);
        #1;
        chk("b2b idle gap", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b relatch", 32'(busy), 32'd1);
        start = 1'b0;
        aIn = $urandom;
        bIn = $urandom;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b second latency", 32'(n), 32'(latOf(32'd9)));
        chk("b2b second result", y, 32'd18);
        @(posedge clk);
        #1;
        // reset in the middle of RUN
        start = 1'b1;
        aIn = 32'd100;
        bIn = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun reset busy", 32'(busy), 32'd0);
        chk("midrun reset done", 32'(done), 32'd0);
        chk("midrun reset y", y, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        chk("no activity after abort", 32'(sawDone), 32'd0);
        runOp(32'd100, 32'd100, "after reset");
        // randomized operands against a*b
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            runOp(ra, rb, $sformatf("rand%0d", i));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/sr_mul_unit.md
SR_MUL_UNIT -- requirements
Module: sr_mul_unit

Interface
REQ-001 SHALL have one clock and one asynchronous, active-high reset.
REQ-002 Ports, clock and reset first:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  operation request from CPU ALU_EXT path; level, held by CPU while stalled.
- a_bi  in  32  multiplicand operand (CPU rs1 value).
- b_bi  in  32  multiplier operand (CPU rs2 value).
- busy_o  out  1  unit owns an operation (state RUN or DONE).
- done_o  out  1  one-cycle completion pulse; drives CPU aluDone.
- y_bo  out  32  result, low 32 bits of a_bi*b_bi.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-004 IDLE: on an edge with start_i=1, SHALL latch a_bi into the multiplicand register, b_bi into the multiplier register, clear the accumulator and the 5-bit iteration counter, and go to RUN; with start_i=0, SHALL stay in IDLE.
REQ-005 RUN, per edge, shift-add step: if multiplier[0]=1, acc <= acc + mcand (mod 2^32); mcand <= mcand << 1; mplr <= mplr >> 1; counter <= counter + 1.
REQ-006 RUN SHALL go to DONE on the edge that performs the 32nd step (counter = 31), unless REQ-015 applies.
REQ-007 On the RUN->DONE edge, y_bo SHALL load the final accumulator value, including that edge's step.
REQ-008 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-009 start_i SHALL be ignored in RUN and DONE; no restart and no operand relatch.
REQ-010 a_bi and b_bi changes after the latching edge SHALL NOT affect the result.
REQ-011 Outputs:
- busy_o = (state != IDLE).
- done_o = (state == DONE).
- Both SHALL be driven directly from the state register, with no combinational path from start_i.
REQ-012 y_bo SHALL hold its value from the RUN->DONE edge until the next RUN->DONE edge.
REQ-013 Latency, full mode: start_i sampled at edge E0; done_o high during the cycle after edge E32; busy_o high from E0 through E33.
REQ-014 Back-to-back: if start_i stays high, the next operation SHALL latch on the edge that leaves DONE+1. That is, DONE->IDLE costs one edge, and the next start is sampled one edge later in IDLE.

Reset
REQ-016 While rst_i=1, SHALL hold:
- state = IDLE
- acc, mcand, mplr, counter = 0
- y_bo = 0
- busy_o = 0, done_o = 0
This takes effect immediately, independent of clk_i.
REQ-017 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done_o pulse; after release, the first edge with start_i=1 starts a fresh operation.

Configuration
REQ-015 With macro SR_MUL_EARLY_EXIT_EN defined, RUN SHALL also go to DONE on any edge where the post-step multiplier value is zero. The minimum RUN length is 1 cycle (b_bi=0 gives done_o after edge E1). Results are identical to full mode.
REQ-018 Without SR_MUL_EARLY_EXIT_EN, RUN SHALL always take exactly 32 cycles regardless of operands.

Verification
REQ-019 a=3, b=5, single start pulse, macro undefined -> done_o high only in the cycle after E32, y_bo=15, busy_o high E0..E33.
REQ-020 a=0xFFFFFFFF, b=0xFFFFFFFF -> y_bo=0x00000001; a=0x00010000, b=0x00010000 -> y_bo=0x00000000 (truncation).
REQ-021 start_i held high continuously, operand pairs (7,6) then (2,9), operands changed mid-RUN -> results 42 then 18; no spurious relatch in DONE.
REQ-022 rst_i pulsed at cycle 10 of RUN (a=100, b=100) -> busy_o=0, done_o=0, y_bo=0 immediately; no done_o pulse; next start yields 10000.
REQ-023 SR_MUL_EARLY_EXIT_EN defined:
- b=0 -> done_o after E1, y_bo=0.
- b=5, a=3 -> done_o after E3, y_bo=15.
- b=0x80000000, a=1 -> done_o after E32, y_bo=0x80000000.
